clk_gate_ctrl: RTL and testbench
================================

# clk_gate_ctrl

Per-domain clock-gate controller that drives the enable inputs of the dual-latch clock-gating cells. Each of N_DOM gated clock domains gets its own request/acknowledge handshake, an idle-hysteresis counter before its clock is shut off, and a wake sequence that waits out the gating cell's enable latency before acknowledging. Simultaneous wake requests are serialised by a round-robin arbiter so that at most one domain turns on per wake slot, which limits inrush. The block sits between the power-management logic or requesters and the bank of gating cells, and runs on the ungated clock.

## Interface
- N_DOM, 4, number of gated domains (2..8)
- IDLE_CYCLES, 16, idle cycles (req=0, busy=0) before a domain's gate closes (≥1)
- WAKE_LAT, 2, cycles from gate_en rise to ack; covers the gating cell's posedge + negedge enable path (≥1)
- CNT_W, 5, counter width; must hold max(IDLE_CYCLES, WAKE_LAT)
- clk  input  1  free-running ungated clock; all state on posedge
- rst  input  1  asynchronous, active-low reset
- req  input  N_DOM  per-domain clock request, level
- busy  input  N_DOM  per-domain activity flag; holds the clock on while high
- force_on  input  N_DOM  config override; domain clock is kept on and never idles out
- gate_en  output  N_DOM  registered enable to each gating cell
- ack  output  N_DOM  registered; domain clock is running and stable for the requester
- wake_active  output  1  registered; a wake sequence is in progress
- dom_on  output  N_DOM  registered; domain is in ON or IDLE_WAIT

## Operation
- Per-domain FSM with states OFF, WAIT_GRANT, WAKE, ON and IDLE_WAIT.
- A domain "wants" its clock when want = req | busy | force_on.
- OFF: gate_en=0, ack=0. If want=1, go to WAIT_GRANT.
- WAIT_GRANT: gate_en=0. On grant from the arbiter, go to WAKE, set gate_en=1 and load wake_cnt=WAKE_LAT-1. If want drops before grant, return to OFF.
- WAKE: gate_en=1, ack=0. wake_cnt decrements each cycle. At wake_cnt=0, go to ON. A wake is never aborted; if want drops during WAKE, the domain still enters ON and then idles out normally.
- ON: gate_en=1 and ack=req. When req=0, busy=0 and force_on=0, go to IDLE_WAIT and load idle_cnt=IDLE_CYCLES-1.
- IDLE_WAIT: gate_en=1, ack=0. If want=1, return to ON; ack=req is registered in the next cycle, with no wake delay. Otherwise idle_cnt decrements; at idle_cnt=0, go to OFF and drop gate_en.
- Arbiter:
  - One grant per cycle, and only when no domain is in WAKE (wake_active=0).
  - Candidates are the domains in WAIT_GRANT.
  - Round-robin: the search starts at rr_ptr; after a grant to domain k, rr_ptr=(k+1) mod N_DOM.
  - rr_ptr is unchanged when no grant is issued.
- wake_active = OR of domains in WAKE.
- Changing force_on takes effect the next cycle, with the same transitions as req.

## Timing
- Reset (rst=0, asynchronous): all domains OFF; gate_en=0, ack=0, dom_on=0, wake_active=0; rr_ptr=0; all counters 0. Release is synchronous to the next posedge.
- Uncontended wake, req rising at cycle 0:
  - cycle 1: WAIT_GRANT
  - cycle 2: gate_en=1, WAKE
  - cycle 2+WAKE_LAT: ack=1
- Back-to-back grants are spaced WAKE_LAT+1 cycles apart, because the next grant waits for wake_active=0.
- Shut-off: req and busy fall at cycle 0; gate_en falls at cycle 1+IDLE_CYCLES. Any want pulse during IDLE_WAIT restarts the full idle count the next time the domain enters IDLE_WAIT.
- ack falls in the cycle after req falls.
- gate_en changes only on posedge clk. The gating cell handles glitch-free clock alignment.
- An async reset during WAKE or IDLE_WAIT forces gate_en=0 immediately, with no handshake.

## Test plan
- Reset mid-wake: with WAKE_LAT=2, req[0]=1; assert rst=0 at cycle 3 -> gate_en=0 and ack=0 asynchronously. After release, domain 0 re-wakes and ack[0]=1 at 4 cycles after release.
- Single wake/sleep: req[1] rises at cycle 0 -> gate_en[1]=1 at cycle 2, ack[1]=1 at cycle 4. req[1] falls at cycle 10 -> ack[1]=0 at cycle 11, gate_en[1]=0 at cycle 27 (IDLE_CYCLES=16).
- Contention: req=4'b1111 at cycle 0 with rr_ptr=0 -> gate_en bits rise in order 0,1,2,3 at cycles 2,5,8,11. wake_active is never high for two domains at once.
- Idle re-request: a domain in IDLE_WAIT with idle_cnt=5 sees a req pulse -> back to ON, ack=1 the next cycle, gate_en never drops, no arbiter grant consumed.
- Busy/force hold: req=0, busy=1 for 40 cycles -> gate_en stays 1 and ack stays 0. force_on=1 with req=busy=0 -> gate_en stays 1 indefinitely. Clearing force_on -> gate_en=0 after IDLE_CYCLES+1 cycles.
- Fairness: domain 2 granted, then req[0] and req[3] pending -> domain 3 granted before domain 0.

Source files
------------

// File: rtl/clk_gate_ctrl.sv
// Per-domain clock-gate enable controller: request/ack handshake, idle hysteresis,
// wake latency and a round-robin arbiter that admits one domain wake at a time.
module clk_gate_ctrl #(
  parameter int N_DOM       = 4,
  parameter int IDLE_CYCLES = 16,
  parameter int WAKE_LAT    = 2,
  parameter int CNT_W       = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_DOM-1:0] req,
  input  logic [N_DOM-1:0] busy,
  input  logic [N_DOM-1:0] force_on,
  output logic [N_DOM-1:0] gate_en,
  output logic [N_DOM-1:0] ack,
  output logic             wake_active,
  output logic [N_DOM-1:0] dom_on
);

  localparam int PTR_W = (N_DOM > 1) ? $clog2(N_DOM) : 1;
  localparam logic [CNT_W-1:0] WAKE_LOAD = CNT_W'(WAKE_LAT - 1);
  localparam logic [CNT_W-1:0] IDLE_LOAD = CNT_W'(IDLE_CYCLES - 1);

  typedef enum logic [2:0] {
    S_OFF,
    S_WAIT_GRANT,
    S_WAKE,
    S_ON,
    S_IDLE_WAIT
  } dom_state_e;

  logic [N_DOM-1:0] want;
  logic [N_DOM-1:0] cand;
  logic [N_DOM-1:0] in_wake;
  logic [N_DOM-1:0] wake_next;
  logic [N_DOM-1:0] grant;

  logic [PTR_W-1:0] rr_ptr_q, rr_ptr_d;
  logic             wake_active_q, wake_active_d;

  logic             hi_found, lo_found, grant_vld;
  logic [PTR_W-1:0] hi_idx, lo_idx, grant_idx;

  // Round-robin pick: lowest candidate at or above rr_ptr, else lowest overall.
  always_comb begin
    hi_found = 1'b0;
    lo_found = 1'b0;
    hi_idx   = '0;
    lo_idx   = '0;
    for (int j = N_DOM - 1; j >= 0; j--) begin
      if (cand[j]) begin
        lo_found = 1'b1;
        lo_idx   = PTR_W'(j);
        if (j >= int'(rr_ptr_q)) begin
          hi_found = 1'b1;
          hi_idx   = PTR_W'(j);
        end
      end
    end
    grant_vld = (hi_found | lo_found) & ~(|in_wake);
    grant_idx = hi_found ? hi_idx : lo_idx;
    for (int j = 0; j < N_DOM; j++) begin
      grant[j] = grant_vld && (grant_idx == PTR_W'(j));
    end
    rr_ptr_d = rr_ptr_q;
    if (grant_vld) begin
      rr_ptr_d = (grant_idx == PTR_W'(N_DOM - 1)) ? '0 : grant_idx + 1'b1;
    end
    wake_active_d = |wake_next;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rr_ptr_q      <= '0;
      wake_active_q <= 1'b0;
    end else begin
      rr_ptr_q      <= rr_ptr_d;
      wake_active_q <= wake_active_d;
    end
  end

  assign wake_active = wake_active_q;

  genvar gi;
  generate
    for (gi = 0; gi < N_DOM; gi++) begin : g_dom
      dom_state_e       state_q, state_d;
      logic [CNT_W-1:0] wake_cnt_q, wake_cnt_d;
      logic [CNT_W-1:0] idle_cnt_q, idle_cnt_d;
      logic             gate_en_q, gate_en_d;
      logic             ack_q, ack_d;
      logic             dom_on_q, dom_on_d;

      assign want[gi]    = req[gi] | busy[gi] | force_on[gi];
      // A domain that lost interest while queued must not consume a grant.
      assign cand[gi]    = (state_q == S_WAIT_GRANT) & want[gi];
      assign in_wake[gi] = (state_q == S_WAKE);

      always_comb begin
        state_d    = state_q;
        wake_cnt_d = wake_cnt_q;
        idle_cnt_d = idle_cnt_q;
        case (state_q)
          S_OFF: begin
            if (want[gi]) state_d = S_WAIT_GRANT;
          end
          S_WAIT_GRANT: begin
            if (grant[gi]) begin
              state_d    = S_WAKE;
              wake_cnt_d = WAKE_LOAD;
            end else if (!want[gi]) begin
              state_d = S_OFF;
            end
          end
          S_WAKE: begin
            // Wake always completes so the gating cell sees a clean enable.
            if (wake_cnt_q == '0) state_d = S_ON;
            else wake_cnt_d = wake_cnt_q - 1'b1;
          end
          S_ON: begin
            if (!want[gi]) begin
              state_d    = S_IDLE_WAIT;
              idle_cnt_d = IDLE_LOAD;
            end
          end
          S_IDLE_WAIT: begin
            if (want[gi]) state_d = S_ON;
            else if (idle_cnt_q == '0) state_d = S_OFF;
            else idle_cnt_d = idle_cnt_q - 1'b1;
          end
          default: state_d = S_OFF;
        endcase
        gate_en_d = (state_d == S_WAKE) || (state_d == S_ON) || (state_d == S_IDLE_WAIT);
        ack_d     = (state_d == S_ON) && req[gi];
        dom_on_d  = (state_d == S_ON) || (state_d == S_IDLE_WAIT);
      end

      assign wake_next[gi] = (state_d == S_WAKE);

      always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
          state_q    <= S_OFF;
          wake_cnt_q <= '0;
          idle_cnt_q <= '0;
          gate_en_q  <= 1'b0;
          ack_q      <= 1'b0;
          dom_on_q   <= 1'b0;
        end else begin
          state_q    <= state_d;
          wake_cnt_q <= wake_cnt_d;
          idle_cnt_q <= idle_cnt_d;
          gate_en_q  <= gate_en_d;
          ack_q      <= ack_d;
          dom_on_q   <= dom_on_d;
        end
      end

      assign gate_en[gi] = gate_en_q;
      assign ack[gi]     = ack_q;
      assign dom_on[gi]  = dom_on_q;
    end
  endgenerate

  // At most one domain may be mid-wake; this bounds inrush.
  a_single_wake: assert property (@(posedge clk) disable iff (!rst) $onehot0(in_wake));
  a_grant_onehot: assert property (@(posedge clk) disable iff (!rst) $onehot0(grant));

endmodule

// File: tb/tb_clk_gate_ctrl.sv
// Bench for clk_gate_ctrl: directed vector table, multi-cycle corner sequences,
// and randomized traffic checked against a deadline-based reference model.
module tb_clk_gate_ctrl;

  localparam int N    = 4;
  localparam int IDLE = 16;
  localparam int WLAT = 2;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic [N-1:0] req = '0;
  logic [N-1:0] busy = '0;
  logic [N-1:0] force_on = '0;
  logic [N-1:0] gate_en;
  logic [N-1:0] ack;
  logic         wake_active;
  logic [N-1:0] dom_on;

  always #5 clk = ~clk;

  clk_gate_ctrl #(
    .N_DOM      (N),
    .IDLE_CYCLES(IDLE),
    .WAKE_LAT   (WLAT),
    .CNT_W      (5)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .req        (req),
    .busy       (busy),
    .force_on   (force_on),
    .gate_en    (gate_en),
    .ack        (ack),
    .wake_active(wake_active),
    .dom_on     (dom_on)
  );

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference model: each domain is described by deadlines (when its wake
  // completes, when its idle window expires) rather than a state register.
  bit           m_gate [N];
  bit           m_pend [N];
  int           m_done [N];
  int           m_off  [N];
  int           m_rr;
  int           m_t;
  logic [N-1:0] m_req;

  task automatic model_reset();
    for (int d = 0; d < N; d++) begin
      m_gate[d] = 1'b0;
      m_pend[d] = 1'b0;
      m_done[d] = 0;
      m_off[d]  = -1;
    end
    m_rr  = 0;
    m_t   = 0;
    m_req = '0;
  endtask

  task automatic model_step(input logic [N-1:0] r, input logic [N-1:0] b, input logic [N-1:0] f);
    logic [N-1:0] w;
    bit           any_wake;
    bit           cnd [N];
    int           n;
    int           d;
    w        = r | b | f;
    n        = m_t + 1;
    any_wake = 1'b0;
    for (int i = 0; i < N; i++) begin
      if (m_gate[i] && m_t < m_done[i]) any_wake = 1'b1;
      cnd[i] = m_pend[i] && w[i];
    end
    for (int i = 0; i < N; i++) begin
      if (!m_gate[i]) begin
        if (m_pend[i] && !w[i]) m_pend[i] = 1'b0;
        else if (!m_pend[i] && w[i]) m_pend[i] = 1'b1;
      end else if (m_t >= m_done[i]) begin
        if (m_off[i] < 0) begin
          if (!w[i]) m_off[i] = n + IDLE;
        end else if (w[i]) begin
          m_off[i] = -1;
        end else if (n == m_off[i]) begin
          m_gate[i] = 1'b0;
          m_off[i]  = -1;
        end
      end
    end
    if (!any_wake) begin
      for (int k = 0; k < N; k++) begin
        d = (m_rr + k) % N;
        if (cnd[d]) begin
          m_gate[d] = 1'b1;
          m_pend[d] = 1'b0;
          m_done[d] = n + WLAT;
          m_off[d]  = -1;
          m_rr      = (d + 1) % N;
          break;
        end
      end
    end
    m_req = r;
    m_t   = n;
  endtask

  task automatic model_out(output logic [N-1:0] g, output logic [N-1:0] a,
                           output logic [N-1:0] on, output logic wa);
    g = '0; a = '0; on = '0; wa = 1'b0;
    for (int d = 0; d < N; d++) begin
      if (m_gate[d]) begin
        g[d] = 1'b1;
        if (m_t >= m_done[d]) begin
          on[d] = 1'b1;
          if (m_off[d] < 0 && m_req[d]) a[d] = 1'b1;
        end else begin
          wa = 1'b1;
        end
      end
    end
  endtask

  task automatic do_reset();
    rst = 1'b0;
    req = '0; busy = '0; force_on = '0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    model_reset();
  endtask

  // Edges until the selected output bit reaches level; 99 if it never does.
  task automatic wait_bit(input int d, input bit use_ack, input bit level, input int max, output int k);
    k = 99;
    for (int i = 1; i <= max; i++) begin
      @(negedge clk);
      if ((use_ack ? ack[d] : gate_en[d]) === level) begin
        k = i;
        break;
      end
    end
  endtask

  typedef struct {
    logic [N-1:0] req;
    logic [N-1:0] busy;
    logic [N-1:0] frc;
    logic [N-1:0] e_gate;
    logic [N-1:0] e_ack;
    logic         e_wa;
    logic [N-1:0] e_on;
  } vec_t;

  vec_t tbl [16];

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int           k;
    int           bad;
    int           multi;
    int           rise [N];
    logic [N-1:0] r, b, f, eg, ea, eo;
    logic         ew;

    tbl[0]  = '{4'b0010, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 1'b0, 4'b0000};
    tbl[1]  = '{4'b0010, 4'b0000, 4'b0000, 4'b0010, 4'b0000, 1'b1, 4'b0000};
    tbl[2]  = '{4'b0010, 4'b0000, 4'b0000, 4'b0010, 4'b0000, 1'b1, 4'b0000};
    tbl[3]  = '{4'b0010, 4'b0000, 4'b0000, 4'b0010, 4'b0010, 1'b0, 4'b0010};
    tbl[4]  = '{4'b0010, 4'b0000, 4'b0000, 4'b0010, 4'b0010, 1'b0, 4'b0010};
    tbl[5]  = '{4'b0000, 4'b0000, 4'b0000, 4'b0010, 4'b0000, 1'b0, 4'b0010};
    tbl[6]  = '{4'b0000, 4'b0000, 4'b0000, 4'b0010, 4'b0000, 1'b0, 4'b0010};
    tbl[7]  = '{4'b0010, 4'b0000, 4'b0000, 4'b0010, 4'b0010, 1'b0, 4'b0010};
    tbl[8]  = '{4'b0000, 4'b0000, 4'b0000, 4'b0010, 4'b0000, 1'b0, 4'b0010};
    tbl[9]  = '{4'b0000, 4'b0010, 4'b0000, 4'b0010, 4'b0000, 1'b0, 4'b0010};
    tbl[10] = '{4'b0000, 4'b0000, 4'b0000, 4'b0010, 4'b0000, 1'b0, 4'b0010};
    tbl[11] = '{4'b0000, 4'b0000, 4'b0100, 4'b0010, 4'b0000, 1'b0, 4'b0010};
    tbl[12] = '{4'b0000, 4'b0000, 4'b0100, 4'b0110, 4'b0000, 1'b1, 4'b0010};
    tbl[13] = '{4'b0000, 4'b0000, 4'b0100, 4'b0110, 4'b0000, 1'b1, 4'b0010};
    tbl[14] = '{4'b0000, 4'b0000, 4'b0100, 4'b0110, 4'b0000, 1'b0, 4'b0110};
    tbl[15] = '{4'b0100, 4'b0000, 4'b0100, 4'b0110, 4'b0100, 1'b0, 4'b0110};

    // Outputs while reset is held.
    #12;
    chk("rst_gate", gate_en, 0);
    chk("rst_ack", ack, 0);
    chk("rst_wa", wake_active, 0);
    chk("rst_on", dom_on, 0);
    $display("reset: gate=%b ack=%b wa=%b on=%b", gate_en, ack, wake_active, dom_on);

    // Directed vector table: one row per clock.
    do_reset();
    for (int i = 0; i < 16; i++) begin
      req = tbl[i].req; busy = tbl[i].busy; force_on = tbl[i].frc;
      @(negedge clk);
      chk($sformatf("tbl%0d_gate", i), gate_en, tbl[i].e_gate);
      chk($sformatf("tbl%0d_ack", i), ack, tbl[i].e_ack);
      chk($sformatf("tbl%0d_wa", i), wake_active, tbl[i].e_wa);
      chk($sformatf("tbl%0d_on", i), dom_on, tbl[i].e_on);
      $display("tbl row %0d: req=%b busy=%b frc=%b gate=%b ack=%b wa=%b on=%b",
               i, req, busy, force_on, gate_en, ack, wake_active, dom_on);
    end

    // Shut-off timing: ack drops next cycle, gate drops IDLE+1 cycles after req falls.
    do_reset();
    req = 4'b0010;
    repeat (6) @(negedge clk);
    chk("shut_pre_ack", ack[1], 1'b1);
    req = '0;
    @(negedge clk);
    chk("shut_ack_fall", ack[1], 1'b0);
    wait_bit(1, 1'b0, 1'b0, 40, k);
    chk("shut_gate_fall_cycle", k + 1, IDLE + 1);
    $display("shutoff: gate fell %0d cycles after req fell", k + 1);

    // Busy hold, then force_on hold, then force release.
    do_reset();
    busy = 4'b0010;
    repeat (4) @(negedge clk);
    bad = 0;
    repeat (40) begin
      @(negedge clk);
      if (gate_en[1] !== 1'b1 || ack[1] !== 1'b0) bad++;
    end
    chk("busy_hold", bad, 0);
    busy = '0; force_on = 4'b0010;
    bad = 0;
    repeat (50) begin
      @(negedge clk);
      if (gate_en[1] !== 1'b1) bad++;
    end
    chk("force_hold", bad, 0);
    force_on = '0;
    wait_bit(1, 1'b0, 1'b0, 40, k);
    chk("force_release_cycle", k, IDLE + 1);
    $display("busy/force: release closed gate after %0d cycles", k);

    // Contention: all four requested together after reset.
    do_reset();
    req = 4'b1111;
    for (int d = 0; d < N; d++) rise[d] = -1;
    multi = 0;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      for (int d = 0; d < N; d++) if (gate_en[d] && rise[d] < 0) rise[d] = i;
      if ($countones(gate_en & ~dom_on) > 1) multi++;
    end
    for (int d = 0; d < N; d++) chk($sformatf("cont_rise%0d", d), rise[d], 2 + 3 * d);
    chk("cont_single_wake", multi, 0);
    $display("contention: rises at %0d %0d %0d %0d", rise[0], rise[1], rise[2], rise[3]);

    // Fairness: after domain 2 is granted, domain 3 beats domain 0.
    do_reset();
    req = 4'b0100;
    repeat (2) @(negedge clk);
    chk("fair_d2_gate", gate_en[2], 1'b1);
    req = 4'b1101;
    rise[0] = -1; rise[3] = -1;
    for (int i = 1; i <= 12; i++) begin
      @(negedge clk);
      if (gate_en[0] && rise[0] < 0) rise[0] = i;
      if (gate_en[3] && rise[3] < 0) rise[3] = i;
    end
    chk("fair_d3_rise", rise[3], 3);
    chk("fair_d0_rise", rise[0], 6);
    $display("fairness: d3 rose at %0d, d0 rose at %0d", rise[3], rise[0]);

    // Reset in the middle of a wake.
    do_reset();
    req = 4'b0001;
    repeat (3) @(negedge clk);
    chk("rmw_pre_gate", gate_en[0], 1'b1);
    #2 rst = 1'b0;
    #1;
    chk("rmw_async_gate", gate_en, 0);
    chk("rmw_async_ack", ack, 0);
    chk("rmw_async_wa", wake_active, 0);
    @(negedge clk);
    rst = 1'b1;
    wait_bit(0, 1'b1, 1'b1, 20, k);
    chk("rmw_ack_after_release", k, 4);
    $display("reset mid-wake: ack %0d cycles after release", k);

    // Randomized traffic against the reference model.
    do_reset();
    r = '0; b = '0; f = '0;
    for (int c = 0; c < 1000; c++) begin
      for (int d = 0; d < N; d++) begin
        if (c < 500) begin
          if ($urandom_range(0, 7) == 0) r[d] = ~r[d];
          if ($urandom_range(0, 15) == 0) b[d] = ~b[d];
          if ($urandom_range(0, 59) == 0) f[d] = ~f[d];
        end else begin
          b[d] = 1'b0; f[d] = 1'b0;
          if ($urandom_range(0, 24) == 0) r[d] = ~r[d];
        end
      end
      req = r; busy = b; force_on = f;
      model_step(r, b, f);
      @(negedge clk);
      model_out(eg, ea, eo, ew);
      chk($sformatf("rand%0d_gate", c), gate_en, eg);
      chk($sformatf("rand%0d_ack", c), ack, ea);
      chk($sformatf("rand%0d_wa", c), wake_active, ew);
      chk($sformatf("rand%0d_on", c), dom_on, eo);
      $display("rand %0d: req=%b busy=%b frc=%b gate=%b ack=%b wa=%b on=%b",
               c, r, b, f, gate_en, ack, wake_active, dom_on);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
